neuron_out_reader: RTL and testbench



---
 rtl/mnist_pkg.sv | 43 ++++
 rtl/neuron_out_reader_if.sv | 35 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/neuron_out_reader.sv | 165 ++++++++++++++++
 tb/tb_neuron_out_reader.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// Shared types and requantization helper for the MNIST accumulator datapath.
// The requant function is the single definition of ReLU + rounding shift +
// saturation, reused by every block that turns accumulator results into
// activations.
package mnist_pkg;

  localparam int ACC_W   = 22;
  localparam int OUT_W   = 8;
  // Largest activation: outputs are non-negative, so the top bit stays clear.
  localparam int ACT_MAX = (1 << (OUT_W - 1)) - 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [OUT_W-1:0] act_t;

  // Activation plus a flag telling whether it was clipped to ACT_MAX.
  typedef struct packed {
    logic sat;
    act_t act;
  } requant_t;

  // ReLU, round-half-up right shift by 'shift' (>=1), then clip to ACT_MAX.
  // The rounding add is done one bit wider than the accumulator so the
  // largest positive input cannot wrap.
  function automatic requant_t requant(input acc_t acc, input int unsigned shift);
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rounded;
    requant_t              res;
    wide    = {acc[ACC_W-1], acc};
    rounded = (wide + ((ACC_W + 1)'(1) << (shift - 1))) >>> shift;
    res.sat = 1'b0;
    res.act = '0;
    if (acc[ACC_W-1]) begin
      res.act = '0;
    end else if (rounded > (ACC_W + 1)'(ACT_MAX)) begin
      res.sat = 1'b1;
      res.act = act_t'(ACT_MAX);
    end else begin
      res.act = rounded[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_out_reader_if.sv
// Handshake bundle for neuron_out_reader: the accumulator-result input
// channel and the activation output channel, both valid/ready.
// 'master' is the environment side (producer of results, consumer of
// activations); 'slave' is the reader block itself.
interface neuron_out_reader_if;

  // Accumulator result channel (upstream -> reader)
  mnist_pkg::acc_t acc_in;
  logic            acc_valid;
  logic            acc_ready;

  // Activation channel (reader -> next layer)
  mnist_pkg::act_t dout;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    output acc_in,
    output acc_valid,
    input  acc_ready,
    input  dout,
    input  dout_valid,
    output dout_ready
  );

  modport slave (
    input  acc_in,
    input  acc_valid,
    output acc_ready,
    output dout,
    output dout_valid,
    input  dout_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter. The head word is read combinationally so a
// word written at an edge is visible at the output in the next cycle.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance: each side moves by one on an effective access.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_rd);
  end

  // Storage array; contents need no reset because empty masks stale words.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/neuron_out_reader.sv
// Consumer end of the neuron accumulator output interface.
// Each accepted 22-bit signed result is requantized (ReLU, rounding shift,
// saturation) into an 8-bit activation and queued in a FIFO that feeds the
// next layer. A frame counter marks every NUM_NEURONS-th result with a
// one-cycle frame_done pulse; sat_flag remembers any saturation until reset.
// Build option: define ARGMAX_EN to add the per-frame argmax tracker and its
// argmax_idx / argmax_valid ports.
module neuron_out_reader
  import mnist_pkg::*;
#(
  parameter int SHIFT       = 8,
  parameter int DEPTH       = 16,
  parameter int NUM_NEURONS = 10,
  localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  neuron_out_reader_if.slave bus,
  output logic               frame_done,
  output logic               sat_flag
`ifdef ARGMAX_EN
  ,
  output logic [IDX_W-1:0]   argmax_idx,
  output logic               argmax_valid
`endif
);

  // ---------------------------------------------------------------------
  // Handshake and datapath
  // ---------------------------------------------------------------------
  logic     ready_en_q;
  logic     fifo_full;
  logic     fifo_empty;
  act_t     fifo_head;
  logic     accept;
  logic     pop;
  requant_t rq;

  assign rq     = requant(bus.acc_in, SHIFT);
  assign accept = bus.acc_valid && bus.acc_ready;
  assign pop    = bus.dout_ready && !fifo_empty;

  // acc_ready looks only at full, so a pop never frees a slot in the same
  // cycle. ready_en_q keeps it low until the first edge after reset.
  assign bus.acc_ready  = ready_en_q && !fifo_full;
  assign bus.dout_valid = !fifo_empty;
  // Head is forced to zero while empty so dout is clean out of reset.
  assign bus.dout       = fifo_empty ? '0 : fifo_head;

  // Releases acc_ready one edge after reset deasserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (rq.act),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Frame counter and status flags
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             sat_flag_q, sat_flag_d;
  logic             last_word;

  assign last_word  = (frame_cnt_q == IDX_W'(NUM_NEURONS - 1));
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_flag_q;

  // Next-state for the frame position, the end-of-frame pulse and the
  // sticky saturation flag.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    sat_flag_d   = sat_flag_q | (accept & rq.sat);
    if (accept) begin
      if (last_word) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + IDX_W'(1);
      end
    end
  end

  // Frame and status registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

`ifdef ARGMAX_EN
  // ---------------------------------------------------------------------
  // Per-frame argmax over the raw signed results
  // ---------------------------------------------------------------------
  acc_t             max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] argmax_idx_q, argmax_idx_d;
  logic             argmax_valid_q, argmax_valid_d;
  logic             take_new;

  // First word of a frame always seeds the tracker; afterwards only a
  // strictly larger value replaces it, so ties keep the lowest index.
  assign take_new     = (frame_cnt_q == '0) || (bus.acc_in > max_val_q);
  assign argmax_idx   = argmax_idx_q;
  assign argmax_valid = argmax_valid_q;

  // Tracker update; the frame-ending word is folded in before the winner
  // is published.
  always_comb begin
    max_val_d      = max_val_q;
    max_idx_d      = max_idx_q;
    argmax_idx_d   = argmax_idx_q;
    argmax_valid_d = 1'b0;
    if (accept) begin
      if (take_new) begin
        max_val_d = bus.acc_in;
        max_idx_d = frame_cnt_q;
      end
      if (last_word) begin
        argmax_idx_d   = take_new ? frame_cnt_q : max_idx_q;
        argmax_valid_d = 1'b1;
      end
    end
  end

  // Argmax registers; the published index holds until the next frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val_q      <= '0;
      max_idx_q      <= '0;
      argmax_idx_q   <= '0;
      argmax_valid_q <= 1'b0;
    end else begin
      max_val_q      <= max_val_d;
      max_idx_q      <= max_idx_d;
      argmax_idx_q   <= argmax_idx_d;
      argmax_valid_q <= argmax_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_out_reader.sv
// Scoreboard bench for neuron_out_reader. The driver pushes the expected
// activation (plain integer arithmetic) at each accepted result; a separate
// monitor pops and compares whenever a word leaves the DUT. Frame pulses,
// sat_flag and (with ARGMAX_EN) the argmax index are modelled the same way.
module tb_neuron_out_reader;

  localparam int SHIFT   = 8;
  localparam int NN      = 10;
  localparam int HALF    = 2 ** (SHIFT - 1);
  localparam int ONE     = 2 ** SHIFT;
  localparam int AMAX    = 127;
  localparam int TIMEOUT = 2000;

  logic clk;
  logic rst;
  logic frame_done;
  logic sat_flag;
`ifdef ARGMAX_EN
  logic [3:0] argmax_idx;
  logic       argmax_valid;
`endif

  neuron_out_reader_if bus ();

  neuron_out_reader #(
    .SHIFT       (SHIFT),
    .DEPTH       (16),
    .NUM_NEURONS (NN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .sat_flag   (sat_flag)
`ifdef ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

  // Scoreboard state
  int exp_q[$];
  int fd_q[$];
  int am_q[$];
  int words[NN];
  int fcnt;
  bit exp_sat;
  int cyc;
  int total;
  int bad;
  bit ready_mode;
  bit ready_fixed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference activation straight from the arithmetic definition.
  function automatic int ref_act(input int v);
    int q;
    if (v < 0) return 0;
    q = (v + HALF) / ONE;
    return (q > AMAX) ? AMAX : q;
  endfunction

  function automatic int rand_val();
    int v;
    case ($urandom_range(0, 3))
      0:       v = -int'($urandom_range(1, 2097152));
      1:       v = int'($urandom_range(0, 40000));
      2:       v = int'($urandom_range(0, 200)) * ONE + (($urandom_range(0, 1) == 1) ? HALF : HALF - 1);
      default: v = int'($urandom_range(0, 2097151));
    endcase
    return v;
  endfunction

  // Record one accepted result in the model.
  task automatic model_accept(input int v);
    int best;
    exp_q.push_back(ref_act(v));
    if (v >= 0 && (v + HALF) / ONE > AMAX) exp_sat = 1'b1;
    words[fcnt] = v;
    fcnt++;
    $display("accept cyc=%0d acc=%0d exp_dout=%0d", cyc, v, ref_act(v));
    if (fcnt == NN) begin
      fd_q.push_back(cyc + 1);
      best = 0;
      for (int i = 1; i < NN; i++) if (words[i] > words[best]) best = i;
      am_q.push_back(best);
      fcnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fd_q.delete();
    am_q.delete();
    fcnt    = 0;
    exp_sat = 1'b0;
  endtask

  // Present one result and hold it until the DUT takes it.
  task automatic send(input int v);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    @(negedge clk);
    bus.acc_in    = 22'(v);
    bus.acc_valid = 1'b1;
    while (!done) begin
      #1;
      if (bus.acc_ready) begin
        model_accept(v);
        done = 1'b1;
      end
      @(posedge clk);
      if (!done) begin
        guard++;
        if (guard >= TIMEOUT) begin
          check("accept_timeout", guard, 0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.acc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Downstream ready: either a fixed level or a random pattern.
  initial begin
    bus.dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.dout_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: compares each leaving word and each pulse with the model.
  initial begin
    int  want;
    bit  exp_fd;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dout_unexpected got=%0d want=none", bus.dout);
          end else begin
            want = exp_q.pop_front();
            $display("pop cyc=%0d dout=%0d want=%0d", cyc, bus.dout, want);
            check("dout", bus.dout, want);
          end
        end
        exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
        if (exp_fd) void'(fd_q.pop_front());
        if (exp_fd || frame_done) check("frame_done", frame_done, exp_fd);
`ifdef ARGMAX_EN
        if (exp_fd || argmax_valid) check("argmax_valid", argmax_valid, exp_fd);
        if (exp_fd && am_q.size() > 0) begin
          want = am_q.pop_front();
          check("argmax_idx", argmax_idx, want);
        end
`endif
      end
    end
  end

  initial begin
    int v17;
    int pattern[NN];
    pattern = '{5, 9, 3, 9, 1, 0, 2, 40, 40, -7};
    total = 0; bad = 0; cyc = 0; fcnt = 0; exp_sat = 1'b0;
    ready_mode = 1'b0; ready_fixed = 1'b0;
    rst = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_acc_ready", bus.acc_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("acc_ready_before_edge", bus.acc_ready, 0);
    @(posedge clk);
    #1;
    check("acc_ready_after_edge", bus.acc_ready, 1);

    // First-word latency and rounding cases
    send(384);
    idle();
    #1;
    check("latency_dout_valid", bus.dout_valid, 1);
    check("latency_dout", bus.dout, 2);
    check("sat_after_384", sat_flag, exp_sat);
    ready_fixed = 1'b1;
    send(-256);
    send(127);
    send(128);
    send(32'h10000);
    for (int i = 0; i < 5; i++) send(i * 1000);
    idle();
    #1;
    check("sat_sticky", sat_flag, exp_sat);
    wait_drain();

    // Fill the FIFO with the output stalled
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) send(rand_val());
    v17 = rand_val();
    @(negedge clk);
    bus.acc_in = 22'(v17);
    #1;
    check("full_acc_ready", bus.acc_ready, 0);
    check("full_dout_valid", bus.dout_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("full_hold", bus.acc_ready, 0);
    end
    ready_fixed = 1'b1;
    send(v17);
    idle();
    wait_drain();

    // Reset in the middle of a frame, then one full patterned frame
    ready_fixed = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send(rand_val());
    idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_dout_valid", bus.dout_valid, 0);
    check("midrst_acc_ready", bus.acc_ready, 0);
    check("midrst_sat_flag", sat_flag, 0);
    @(negedge clk);
    rst = 1'b1;
    ready_fixed = 1'b1;
    for (int i = 0; i < NN; i++) send(pattern[i] * ONE);
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    check("frame_pulse_seen", fd_q.size(), 0);

    // Randomized traffic with random downstream back-pressure
    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        if ($urandom_range(0, 1) == 1) idle();
      end
      send(rand_val());
    end
    idle();
    ready_mode = 1'b0;
    ready_fixed = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    #1;
    check("end_dout_valid", bus.dout_valid, 0);
    check("end_frames", fd_q.size(), 0);
    check("end_sat_flag", sat_flag, exp_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
